// File: rtl/rdm_h2c_mem_engine_if.sv
// rdm_h2c_mem_engine_if: H2C/C2H AXI-Stream and DDR4 AXI4 bus bundle for the command engine
// Ports: master = engine view (H2C sink, C2H source, AXI4 master); slave = host/MIG view
interface rdm_h2c_mem_engine_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32
);
  logic [DATA_W-1:0] s_axis_h2c_tdata;
  logic s_axis_h2c_tvalid, s_axis_h2c_tlast, s_axis_h2c_tready;
  logic [DATA_W-1:0] m_axis_c2h_tdata;
  logic [DATA_W/8-1:0] m_axis_c2h_tkeep;
  logic m_axis_c2h_tvalid, m_axis_c2h_tlast, m_axis_c2h_tready;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize;
  logic [1:0] m_axi_awburst, m_axi_arburst;
  logic m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0] m_axi_bresp, m_axi_rresp;
  logic m_axi_bvalid, m_axi_bready;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;
  modport master (
    input  s_axis_h2c_tdata, s_axis_h2c_tvalid, s_axis_h2c_tlast, m_axis_c2h_tready,
           m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid, m_axi_arready,
           m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output s_axis_h2c_tready, m_axis_c2h_tdata, m_axis_c2h_tkeep, m_axis_c2h_tvalid, m_axis_c2h_tlast,
           m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
           m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
           m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready
  );
  modport slave (
    output s_axis_h2c_tdata, s_axis_h2c_tvalid, s_axis_h2c_tlast, m_axis_c2h_tready,
           m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid, m_axi_arready,
           m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  s_axis_h2c_tready, m_axis_c2h_tdata, m_axis_c2h_tkeep, m_axis_c2h_tvalid, m_axis_c2h_tlast,
           m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
           m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
           m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/rdm_h2c_mem_engine.sv
// rdm_h2c_mem_engine: H2C command engine moving stream packets to/from DDR4 over AXI4, one transaction at a time
// Ports: user_clk; sys_rst_n (async, active low); bus = H2C/C2H streams + AXI4 master;
//        busy = not idle; err_cnt = saturating count of protocol and response errors
module rdm_h2c_mem_engine #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32,
  parameter int ERR_W = 16
) (
  input  logic user_clk,
  input  logic sys_rst_n,
  rdm_h2c_mem_engine_if.master bus,
  output logic busy,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int LSB = $clog2(DATA_W/8);
  typedef enum logic [2:0] {IDLE, WR_AW, WR_DATA, WR_PAD, WR_RESP, RD_AR, RD_DATA, DRAIN} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] addr;
  logic [7:0] len, cnt, op;
  logic pad, drain, up, err, last, is_wr, is_rd, h2c_hs, w_hs, r_hs;
  assign op = bus.s_axis_h2c_tdata[7:0];
  assign last = bus.s_axis_h2c_tlast;
  assign is_wr = op == 8'h01;
  assign is_rd = op == 8'h02;
  assign h2c_hs = bus.s_axis_h2c_tvalid && bus.s_axis_h2c_tready;
  assign w_hs = bus.m_axi_wvalid && bus.m_axi_wready;
  assign r_hs = bus.m_axi_rvalid && bus.m_axi_rready;
  assign bus.m_axi_awaddr = addr;
  assign bus.m_axi_araddr = addr;
  assign bus.m_axi_awlen = len;
  assign bus.m_axi_arlen = len;
  assign bus.m_axi_awsize = 3'(LSB);
  assign bus.m_axi_arsize = 3'(LSB);
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axis_c2h_tdata = bus.m_axi_rdata;
  assign bus.m_axis_c2h_tkeep = '1;
  // header: write flags a missing payload; read flags a payload; any other opcode is always bad
  assign err = (state == IDLE && h2c_hs && (is_wr ? last : !(is_rd && last)))
    || (state == WR_DATA && w_hs && bus.m_axi_wlast != last)
    || (state == WR_RESP && bus.m_axi_bvalid && bus.m_axi_bresp != 2'b00)
    || (state == RD_DATA && r_hs && bus.m_axi_rresp != 2'b00);
  always_ff @(posedge user_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (h2c_hs) next = is_wr ? WR_AW : (is_rd && last) ? RD_AR : last ? IDLE : DRAIN;
      WR_AW:   if (bus.m_axi_awready) next = pad ? WR_PAD : WR_DATA;
      WR_DATA: if (w_hs) next = bus.m_axi_wlast ? WR_RESP : last ? WR_PAD : WR_DATA;
      WR_PAD:  if (w_hs && bus.m_axi_wlast) next = WR_RESP;
      WR_RESP: if (bus.m_axi_bvalid) next = drain ? DRAIN : IDLE;
      RD_AR:   if (bus.m_axi_arready) next = RD_DATA;
      RD_DATA: if (r_hs && bus.m_axi_rlast) next = IDLE;
      DRAIN:   if (h2c_hs && last) next = IDLE;
      default: next = IDLE;
    endcase
  end
  // up keeps h2c tready low while reset is held and for the first cycle after release
  always_comb begin
    bus.s_axis_h2c_tready = (state == IDLE && up) || state == DRAIN || (state == WR_DATA && bus.m_axi_wready);
    bus.m_axi_awvalid = state == WR_AW;
    bus.m_axi_wvalid = state == WR_PAD || (state == WR_DATA && bus.s_axis_h2c_tvalid);
    bus.m_axi_wdata = state == WR_DATA ? bus.s_axis_h2c_tdata : '0;
    bus.m_axi_wstrb = state == WR_DATA ? '1 : '0;
    bus.m_axi_wlast = (state == WR_DATA || state == WR_PAD) && cnt == 8'd0;
    bus.m_axi_bready = state == WR_RESP;
    bus.m_axi_arvalid = state == RD_AR;
    bus.m_axi_rready = state == RD_DATA && bus.m_axis_c2h_tready;
    bus.m_axis_c2h_tvalid = state == RD_DATA && bus.m_axi_rvalid;
    bus.m_axis_c2h_tlast = state == RD_DATA && bus.m_axi_rlast;
    busy = state != IDLE;
  end
  always_ff @(posedge user_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      addr <= '0;
      len <= '0;
      cnt <= '0;
      pad <= 1'b0;
      drain <= 1'b0;
      up <= 1'b0;
      err_cnt <= '0;
    end else begin
      up <= 1'b1;
      if (state == IDLE && h2c_hs) begin
        addr <= {bus.s_axis_h2c_tdata[64+LSB +: ADDR_W-LSB], {LSB{1'b0}}};
        len <= bus.s_axis_h2c_tdata[15:8];
        cnt <= bus.s_axis_h2c_tdata[15:8];
        pad <= last;
        drain <= 1'b0;
      end
      if (w_hs && cnt != 8'd0) cnt <= cnt - 8'd1;
      if (state == WR_DATA && w_hs && bus.m_axi_wlast && !last) drain <= 1'b1;
      if (err && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
    end
endmodule

// File: tb/tb_rdm_h2c_mem_engine.sv
// tb_rdm_h2c_mem_engine: randomized self-checking bench with an AXI4 memory slave and a packet-level reference model
module tb_rdm_h2c_mem_engine;
  localparam int DW = 512, AW = 32, EW = 16, SB = DW/8;
  typedef logic [DW+SB:0] cv_t;
  typedef logic [DW:0] hbeat_t;
  typedef logic [DW+2:0] rbeat_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  rdm_h2c_mem_engine_if #(.DATA_W(DW), .ADDR_W(AW)) b ();
  logic busy;
  logic [EW-1:0] err_cnt;
  rdm_h2c_mem_engine #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(EW)) dut (
    .user_clk(clk), .sys_rst_n(rst_n), .bus(b), .busy(busy), .err_cnt(err_cnt));
  int checks = 0, errors = 0, exp_err = 0;
  hbeat_t h2c_q[$];
  rbeat_t r_q[$];
  logic [1:0] b_q[$];
  cv_t w_obs[$], c2h_obs[$], exp_w[$], exp_c[$];
  logic [AW+7:0] aw_obs[$], ar_obs[$], exp_aw[$], exp_ar[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  bit tog = 1'b0;
  bit h2c_f, b_f, r_f;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] mw;
  task automatic check(input string tag, input cv_t got, input cv_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction
  // host, C2H sink and DDR4 memory slave; inputs change on negedge, handshakes sampled 1ns later
  always @(negedge clk) begin
    if (!rst_n) begin
      {h2c_f, b_f, r_f} = 3'b000;
      h2c_q.delete();
      r_q.delete();
      b_q.delete();
      b.s_axis_h2c_tvalid = 1'b0;
      b.s_axis_h2c_tlast = 1'b0;
      b.s_axis_h2c_tdata = '0;
      b.m_axis_c2h_tready = 1'b0;
      b.m_axi_awready = 1'b0;
      b.m_axi_wready = 1'b0;
      b.m_axi_arready = 1'b0;
      b.m_axi_bvalid = 1'b0;
      b.m_axi_bresp = 2'b00;
      b.m_axi_rvalid = 1'b0;
      {b.m_axi_rlast, b.m_axi_rresp, b.m_axi_rdata} = '0;
    end else begin
      if (h2c_f) begin void'(h2c_q.pop_front()); b.s_axis_h2c_tvalid = 1'b0; end
      if (b_f) begin void'(b_q.pop_front()); b.m_axi_bvalid = 1'b0; end
      if (r_f) begin void'(r_q.pop_front()); b.m_axi_rvalid = 1'b0; end
      if (!b.s_axis_h2c_tvalid && h2c_q.size() > 0 && $urandom_range(3) != 0) begin
        b.s_axis_h2c_tvalid = 1'b1;
        {b.s_axis_h2c_tlast, b.s_axis_h2c_tdata} = h2c_q[0];
      end
      if (!b.m_axi_bvalid && b_q.size() > 0 && $urandom_range(1) != 0) begin
        b.m_axi_bvalid = 1'b1;
        b.m_axi_bresp = b_q[0];
      end
      if (!b.m_axi_rvalid && r_q.size() > 0 && $urandom_range(3) != 0) begin
        b.m_axi_rvalid = 1'b1;
        {b.m_axi_rlast, b.m_axi_rresp, b.m_axi_rdata} = r_q[0];
      end
      b.m_axi_awready = 1'($urandom_range(1));
      b.m_axi_arready = 1'($urandom_range(1));
      b.m_axi_wready = $urandom_range(3) != 0;
      b.m_axis_c2h_tready = tog ? !b.m_axis_c2h_tready : $urandom_range(3) != 0;
      #1;
      h2c_f = b.s_axis_h2c_tvalid && b.s_axis_h2c_tready;
      b_f = b.m_axi_bvalid && b.m_axi_bready;
      r_f = b.m_axi_rvalid && b.m_axi_rready;
      if (b.m_axi_awvalid && b.m_axi_awready) begin
        aw_obs.push_back({b.m_axi_awaddr, b.m_axi_awlen});
        wa = b.m_axi_awaddr;
      end
      if (b.m_axi_wvalid && b.m_axi_wready) begin
        w_obs.push_back({b.m_axi_wlast, b.m_axi_wstrb, b.m_axi_wdata});
        mw = mem.exists(wa) ? mem[wa] : '0;
        for (int k = 0; k < SB; k++) if (b.m_axi_wstrb[k]) mw[k*8 +: 8] = b.m_axi_wdata[k*8 +: 8];
        mem[wa] = mw;
        wa += AW'(SB);
        if (b.m_axi_wlast) b_q.push_back(bresp_cfg);
      end
      if (b.m_axi_arvalid && b.m_axi_arready) begin
        ar_obs.push_back({b.m_axi_araddr, b.m_axi_arlen});
        ra = b.m_axi_araddr;
        for (int i = 0; i <= int'(b.m_axi_arlen); i++) begin
          mw = mem.exists(ra) ? mem[ra] : '0;
          r_q.push_back({i == int'(b.m_axi_arlen), rresp_cfg, mw});
          ra += AW'(SB);
        end
      end
      if (b.m_axis_c2h_tvalid && b.m_axis_c2h_tready)
        c2h_obs.push_back({b.m_axis_c2h_tlast, b.m_axis_c2h_tkeep, b.m_axis_c2h_tdata});
    end
  end
  task automatic clear_all();
    exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_c.delete();
    aw_obs.delete(); ar_obs.delete(); w_obs.delete(); c2h_obs.delete();
  endtask
  task automatic settle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (n < 3000 && (h2c_q.size() > 0 || b.s_axis_h2c_tvalid || busy || r_q.size() > 0 || b_q.size() > 0));
    check({tag, ".done"}, cv_t'(n < 3000), cv_t'(1));
    check({tag, ".aw_n"}, cv_t'(aw_obs.size()), cv_t'(exp_aw.size()));
    foreach (exp_aw[i]) if (i < aw_obs.size()) check($sformatf("%s.aw%0d", tag, i), cv_t'(aw_obs[i]), cv_t'(exp_aw[i]));
    check({tag, ".ar_n"}, cv_t'(ar_obs.size()), cv_t'(exp_ar.size()));
    foreach (exp_ar[i]) if (i < ar_obs.size()) check($sformatf("%s.ar%0d", tag, i), cv_t'(ar_obs[i]), cv_t'(exp_ar[i]));
    check({tag, ".w_n"}, cv_t'(w_obs.size()), cv_t'(exp_w.size()));
    foreach (exp_w[i]) if (i < w_obs.size()) check($sformatf("%s.w%0d", tag, i), w_obs[i], exp_w[i]);
    check({tag, ".c2h_n"}, cv_t'(c2h_obs.size()), cv_t'(exp_c.size()));
    foreach (exp_c[i]) if (i < c2h_obs.size()) check($sformatf("%s.c2h%0d", tag, i), c2h_obs[i], exp_c[i]);
    check({tag, ".err"}, cv_t'(err_cnt), cv_t'(exp_err > 65535 ? 65535 : exp_err));
    clear_all();
  endtask
  // reference model: what one packet must produce on AXI and C2H, and how many errors it raises
  task automatic pkt(input string tag, input logic [7:0] op, input int len, input logic [AW-1:0] addr,
                     input int nb, input logic [1:0] br = 2'b00, input logic [1:0] rr = 2'b00, input bit wait_done = 1'b1);
    logic [DW-1:0] d = rnd();
    logic [AW-1:0] a = {addr[AW-1:6], 6'b0};
    bresp_cfg = br;
    rresp_cfg = rr;
    d[7:0] = op;
    d[15:8] = 8'(len);
    d[64 +: AW] = addr;
    h2c_q.push_back({nb == 0, d});
    for (int i = 0; i < nb; i++) begin
      d = rnd();
      h2c_q.push_back({i == nb - 1, d});
      if (op == 8'h01 && i <= len) begin
        exp_w.push_back({i == len, {SB{1'b1}}, d});
        ref_mem[a + AW'(i*SB)] = d;
      end
    end
    if (op == 8'h01) begin
      exp_aw.push_back({a, 8'(len)});
      for (int i = nb; i <= len; i++) exp_w.push_back({i == len, {SB{1'b0}}, {DW{1'b0}}});
      if (nb != len + 1) exp_err++;
      if (br != 2'b00) exp_err++;
    end else if (op == 8'h02 && nb == 0) begin
      exp_ar.push_back({a, 8'(len)});
      for (int i = 0; i <= len; i++) begin
        d = ref_mem.exists(a + AW'(i*SB)) ? ref_mem[a + AW'(i*SB)] : '0;
        exp_c.push_back({i == len, {SB{1'b1}}, d});
      end
      if (rr != 2'b00) exp_err += len + 1;
    end else exp_err++;
    if (wait_done) settle(tag);
  endtask
  task automatic check_quiet(input string tag);
    check({tag, ".ctl"}, cv_t'({b.s_axis_h2c_tready, b.m_axis_c2h_tvalid, b.m_axis_c2h_tlast, b.m_axi_awvalid,
      b.m_axi_wvalid, b.m_axi_wlast, b.m_axi_bready, b.m_axi_arvalid, b.m_axi_rready, busy}), cv_t'(0));
    check({tag, ".addr"}, cv_t'({b.m_axi_awaddr, b.m_axi_awlen, b.m_axi_araddr, b.m_axi_arlen}), cv_t'(0));
    check({tag, ".err"}, cv_t'(err_cnt), cv_t'(0));
  endtask
  initial begin
    int n;
    logic [7:0] op;
    int len, nb;
    repeat (3) @(negedge clk);
    #2;
    check_quiet("reset");
    check("consts", cv_t'({b.m_axi_awsize, b.m_axi_awburst, b.m_axi_arsize, b.m_axi_arburst}), cv_t'({3'd6, 2'b01, 3'd6, 2'b01}));
    rst_n = 1'b1;
    pkt("t1_write", 8'h01, 3, 32'h1000, 4);
    tog = 1'b1;
    pkt("t2_read", 8'h02, 1, 32'h1040, 0);
    tog = 1'b0;
    pkt("t3_short", 8'h01, 3, 32'h2000, 2);
    pkt("t4_long", 8'h01, 0, 32'h2100, 3);
    pkt("t4_read", 8'h02, 0, 32'h2100, 0);
    pkt("t5_illegal", 8'h07, 3, 32'h0, 5);
    pkt("t5_slverr", 8'h01, 1, 32'h2200, 2, 2'b10);
    pkt("rd_payload", 8'h02, 2, 32'h1000, 2);
    pkt("wr_nopay", 8'h01, 2, 32'h2300, 0);
    pkt("ill_single", 8'h09, 0, 32'h0, 0);
    pkt("rd_slverr", 8'h02, 1, 32'h1013, 0, 2'b00, 2'b10);
    pkt("t6_abort", 8'h01, 7, 32'h8000, 8, 2'b00, 2'b00, 1'b0);
    n = 0;
    while (w_obs.size() < 2 && n < 500) begin @(negedge clk); #2; n++; end
    check("t6_reach_beat2", cv_t'(w_obs.size() >= 2), cv_t'(1));
    #1 rst_n = 1'b0;
    #1;
    check_quiet("t6_reset");
    @(negedge clk);
    @(negedge clk);
    #2;
    clear_all();
    exp_err = 0;
    rst_n = 1'b1;
    pkt("t6_write", 8'h01, 3, 32'h3000, 4);
    pkt("t6_read", 8'h02, 3, 32'h3000, 0);
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 15);
      tog = $urandom_range(3) == 0;
      case ($urandom_range(9))
        0: op = 8'($urandom_range(3, 255));
        1, 2, 3, 4: op = 8'h01;
        default: op = 8'h02;
      endcase
      nb = op == 8'h01 ? ($urandom_range(3) == 0 ? $urandom_range(0, len + 3) : len + 1)
         : op == 8'h02 ? ($urandom_range(5) == 0 ? $urandom_range(1, 3) : 0) : $urandom_range(0, 4);
      pkt($sformatf("rnd%0d", t), op, len, AW'($urandom_range(0, 32'h3fff)), nb,
          $urandom_range(7) == 0 ? 2'b10 : 2'b00, $urandom_range(7) == 0 ? 2'b11 : 2'b00);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
